// File: rtl/multi_byte_add_sequencer_if.sv
// Bundles the request, byte-adder and result handshakes of the multi-byte add sequencer.
// The sequencer takes the slave view; whoever feeds it and models the adder takes the master view.
interface multi_byte_add_sequencer_if #(
   parameter int NUM_BYTES = 4
);
   localparam int WIDTH = 8 * NUM_BYTES;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;

   logic [7:0]       add_a;
   logic [7:0]       add_b;
   logic             add_cin;
   logic             add_valid;
   logic [7:0]       add_sum;
   logic             add_cout;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
      output in_ready, add_a, add_b, add_cin, add_valid, out_valid, out_sum, out_cout
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
      input  in_ready, add_a, add_b, add_cin, add_valid, out_valid, out_sum, out_cout
   );
endinterface

// File: rtl/multi_byte_add_sequencer.sv
// Splits one wide add into LSB-first byte operations on a fixed-latency 8-bit adder,
// chaining carries between bytes and presenting the assembled result on a valid/ready output.
module multi_byte_add_sequencer #(
   parameter int NUM_BYTES   = 4,
   parameter int ADD_LATENCY = 3
) (
   input logic                          clk,
   input logic                          reset,
   multi_byte_add_sequencer_if.slave    bus
);
   localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int WAIT_W = $clog2(ADD_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

   state_e                      state_q, state_d;
   logic [NUM_BYTES-1:0][7:0]   aReg_q, aReg_d;
   logic [NUM_BYTES-1:0][7:0]   bReg_q, bReg_d;
   logic [NUM_BYTES-1:0][7:0]   sum_q, sum_d;
   logic                        carry_q, carry_d;
   logic                        cout_q, cout_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [WAIT_W-1:0]           wait_q, wait_d;
   logic                        sampleNow;
   logic                        lastByte;

   assign sampleNow = (state_q == ISSUE) && (wait_q == WAIT_W'(ADD_LATENCY));
   assign lastByte  = (idx_q == IDX_W'(NUM_BYTES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         aReg_q  <= '0;
         bReg_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         aReg_q  <= aReg_d;
         bReg_q  <= bReg_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
      end
   end

   // The adder result is only trusted on the cycle the wait counter reaches the pipe depth.
   always_comb begin
      state_d = state_q;
      aReg_d  = aReg_q;
      bReg_d  = bReg_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               aReg_d  = bus.in_a;
               bReg_d  = bus.in_b;
               carry_d = bus.in_cin;
               idx_d   = '0;
               wait_d  = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (sampleNow) begin
               sum_d[idx_q] = bus.add_sum;
               carry_d      = bus.add_cout;
               wait_d       = '0;
               if (lastByte) begin
                  cout_d  = bus.add_cout;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte operands come straight from the captured request, so they stay put for the whole wait.
   always_comb begin
      bus.in_ready  = (state_q == IDLE) && !reset;
      bus.add_a     = 8'h00;
      bus.add_b     = 8'h00;
      bus.add_cin   = 1'b0;
      bus.add_valid = 1'b0;
      bus.out_valid = (state_q == DONE);
      bus.out_sum   = sum_q;
      bus.out_cout  = cout_q;
      if (state_q == ISSUE) begin
         bus.add_a     = aReg_q[idx_q];
         bus.add_b     = bReg_q[idx_q];
         bus.add_cin   = carry_q;
         bus.add_valid = 1'b1;
      end
   end
endmodule

// File: tb/tb_multi_byte_add_sequencer.sv
// Scoreboard bench for multi_byte_add_sequencer: a default 4-byte/latency-3 instance and a 1-byte/latency-1 instance,
// each driving a behavioural adder pipe.
module tb_multi_byte_add_sequencer;
   localparam int NB   = 4;
   localparam int LAT  = 3;
   localparam int LAT1 = 1;
   localparam int EXP_LATENCY = NB * (LAT + 1) + 1;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   logic [32:0] expQ[$];
   logic [8:0]  expQ1[$];

   multi_byte_add_sequencer_if #(.NUM_BYTES(NB)) bus ();
   multi_byte_add_sequencer_if #(.NUM_BYTES(1))  bus1 ();

   multi_byte_add_sequencer #(.NUM_BYTES(NB), .ADD_LATENCY(LAT)) u0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   multi_byte_add_sequencer #(.NUM_BYTES(1), .ADD_LATENCY(LAT1)) u1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   logic [8:0] pipe0 [LAT];
   logic [8:0] pipe1;

   always @(posedge clk) begin
      pipe0[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};
      for (int i = 1; i < LAT; i++) pipe0[i] <= pipe0[i-1];
      pipe1 <= {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {8'd0, bus1.add_cin};
   end

   assign bus.add_sum   = pipe0[LAT-1][7:0];
   assign bus.add_cout  = pipe0[LAT-1][8];
   assign bus1.add_sum  = pipe1[7:0];
   assign bus1.add_cout = pipe1[8];

   // Called at a negedge; returns at the negedge where out_valid is first seen (latency -1 on timeout).
   task automatic runAdd(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         output int latency, output int validCycles,
                         output logic [NB-1:0] cinSeq, output int opErrors);
      int n;
      int k;
      int byteIdx;
      logic prevCin;
      latency     = -1;
      validCycles = 0;
      cinSeq      = '0;
      opErrors    = 0;
      prevCin     = 1'b0;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_valid = 1'b1;
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (bus.in_ready !== 1'b1) begin
         bus.in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 1;
      while (n <= 100) begin
         if (bus.out_valid === 1'b1) begin
            latency = n;
            break;
         end
         if (bus.add_valid === 1'b1) begin
            validCycles++;
            byteIdx = (n - 1) / (LAT + 1);
            if (byteIdx >= NB) begin
               opErrors++;
            end else begin
               if (bus.add_a !== a[8*byteIdx +: 8] || bus.add_b !== b[8*byteIdx +: 8]) opErrors++;
               if ((n - 1) % (LAT + 1) == 0) cinSeq[byteIdx] = bus.add_cin;
               else if (bus.add_cin !== prevCin) opErrors++;
            end
            prevCin = bus.add_cin;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin);
      expQ.push_back({1'b0, a} + {1'b0, b} + {32'd0, cin});
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.add_a, bus.add_b, bus.add_cin, bus.add_valid, bus.in_ready} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got ov=%b sum=%h co=%b a=%h b=%h cin=%b av=%b ir=%b, want all zero",
                  bus.out_valid, bus.out_sum, bus.out_cout, bus.add_a, bus.add_b, bus.add_cin, bus.add_valid, bus.in_ready);
      end
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_release_ready: got %b/%b want 1/1", bus.in_ready, bus1.in_ready);
      end
   endtask

   task automatic test_basic();
      int lat, vc, oe;
      logic [NB-1:0] cs;
      logic [32:0] exp;
      bus.out_ready = 1'b1;
      applyStimulus(32'h0000_0001, 32'h0000_0001, 1'b0);
      runAdd(32'h0000_0001, 32'h0000_0001, 1'b0, lat, vc, cs, oe);
      exp = expQ.pop_front();
      vectors++;
      if (lat != EXP_LATENCY) begin
         miscompares++;
         $display("[TB] FAIL basic_latency: got %0d want %0d", lat, EXP_LATENCY);
      end
      vectors++;
      if ({bus.out_cout, bus.out_sum} !== exp) begin
         miscompares++;
         $display("[TB] FAIL basic_result: got %h want %h", {bus.out_cout, bus.out_sum}, exp);
      end
      vectors++;
      if (vc != NB * (LAT + 1) || oe != 0) begin
         miscompares++;
         $display("[TB] FAIL basic_issue: got %0d valid cycles, %0d operand errors, want %0d and 0", vc, oe, NB * (LAT + 1));
      end
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL basic_drop: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_ripple();
      int lat, vc, oe;
      logic [NB-1:0] cs;
      logic [32:0] exp;
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      runAdd(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, vc, cs, oe);
      exp = expQ.pop_front();
      vectors++;
      if (lat < 0 || {bus.out_cout, bus.out_sum} !== exp) begin
         miscompares++;
         $display("[TB] FAIL ripple_result: got %h (latency %0d) want %h", {bus.out_cout, bus.out_sum}, lat, exp);
      end
      vectors++;
      if (cs !== 4'b1110 || oe != 0) begin
         miscompares++;
         $display("[TB] FAIL ripple_cin_seq: got %b (%0d operand errors) want 1110", cs, oe);
      end
      @(negedge clk);
   endtask

   task automatic test_mixed();
      int lat, vc, oe;
      logic [NB-1:0] cs;
      logic [32:0] exp;
      applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      runAdd(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, lat, vc, cs, oe);
      exp = expQ.pop_front();
      vectors++;
      if (lat != EXP_LATENCY || {bus.out_cout, bus.out_sum} !== exp) begin
         miscompares++;
         $display("[TB] FAIL mixed_result: got %h latency %0d want %h latency %0d", {bus.out_cout, bus.out_sum}, lat, exp, EXP_LATENCY);
      end
      vectors++;
      if (cs !== 4'b0111 || oe != 0) begin
         miscompares++;
         $display("[TB] FAIL mixed_cin_seq: got %b (%0d operand errors) want 0111", cs, oe);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat, vc, oe, n;
      logic [NB-1:0] cs;
      logic [32:0] held;
      logic [32:0] exp;
      bus.out_ready = 1'b0;
      applyStimulus(32'hDEAD_BEEF, 32'h0102_0304, 1'b0);
      runAdd(32'hDEAD_BEEF, 32'h0102_0304, 1'b0, lat, vc, cs, oe);
      held = expQ.pop_front();
      vectors++;
      if (lat < 0 || {bus.out_cout, bus.out_sum} !== held) begin
         miscompares++;
         $display("[TB] FAIL hold_first_result: got %h (latency %0d) want %h", {bus.out_cout, bus.out_sum}, lat, held);
      end
      bus.in_a     = 32'h0000_0010;
      bus.in_b     = 32'h0000_0020;
      bus.in_cin   = 1'b0;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if ({bus.out_valid, bus.in_ready, bus.add_valid} !== 3'b100 || {bus.out_cout, bus.out_sum} !== held) begin
            miscompares++;
            $display("[TB] FAIL hold_cycle%0d: got ov/ir/av=%b%b%b result %h want 100 result %h",
                     c, bus.out_valid, bus.in_ready, bus.add_valid, {bus.out_cout, bus.out_sum}, held);
         end
      end
      applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || {bus.out_cout, bus.out_sum} !== held) begin
         miscompares++;
         $display("[TB] FAIL release_idle: got ov=%b ir=%b result %h want 0 1 %h", bus.out_valid, bus.in_ready, {bus.out_cout, bus.out_sum}, held);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.add_valid !== 1'b1 || bus.add_a !== 8'h10 || bus.add_b !== 8'h20) begin
         miscompares++;
         $display("[TB] FAIL pending_accept: got av=%b a=%h b=%h want 1 10 20", bus.add_valid, bus.add_a, bus.add_b);
      end
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      exp = expQ.pop_front();
      vectors++;
      if (bus.out_valid !== 1'b1 || {bus.out_cout, bus.out_sum} !== exp) begin
         miscompares++;
         $display("[TB] FAIL pending_result: got ov=%b result %h want 1 %h", bus.out_valid, {bus.out_cout, bus.out_sum}, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, vc, oe, n;
      logic [NB-1:0] cs;
      logic [32:0] exp;
      bus.out_ready = 1'b1;
      bus.in_a      = 32'h1111_1111;
      bus.in_b      = 32'h2222_2222;
      bus.in_cin    = 1'b0;
      bus.in_valid  = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2 * (LAT + 1) + 2) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.add_a, bus.add_b, bus.add_cin, bus.add_valid, bus.in_ready} !== '0) begin
         miscompares++;
         $display("[TB] FAIL midreset_outputs: got ov=%b sum=%h co=%b a=%h b=%h cin=%b av=%b ir=%b, want all zero",
                  bus.out_valid, bus.out_sum, bus.out_cout, bus.add_a, bus.add_b, bus.add_cin, bus.add_valid, bus.in_ready);
      end
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_idle: got ir=%b ov=%b want 1 0", bus.in_ready, bus.out_valid);
      end
      applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0);
      runAdd(32'h0000_0005, 32'h0000_0003, 1'b0, lat, vc, cs, oe);
      exp = expQ.pop_front();
      vectors++;
      if (lat != EXP_LATENCY || {bus.out_cout, bus.out_sum} !== exp) begin
         miscompares++;
         $display("[TB] FAIL midreset_next_add: got %h latency %0d want %h latency %0d", {bus.out_cout, bus.out_sum}, lat, exp, EXP_LATENCY);
      end
      @(negedge clk);
   endtask

   task automatic test_single_byte();
      int n;
      logic [8:0] exp;
      bus1.out_ready = 1'b1;
      expQ1.push_back({1'b0, 8'hFF} + {1'b0, 8'h01} + 9'd1);
      bus1.in_a     = 8'hFF;
      bus1.in_b     = 8'h01;
      bus1.in_cin   = 1'b1;
      bus1.in_valid = 1'b1;
      n = 0;
      while (bus1.in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus1.in_valid = 1'b0;
      n = 1;
      while (bus1.out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      exp = expQ1.pop_front();
      vectors++;
      if (bus1.out_valid !== 1'b1 || n != 1 * (LAT1 + 1) + 1) begin
         miscompares++;
         $display("[TB] FAIL single_latency: got ov=%b at %0d want 1 at %0d", bus1.out_valid, n, 1 * (LAT1 + 1) + 1);
      end
      vectors++;
      if ({bus1.out_cout, bus1.out_sum} !== exp) begin
         miscompares++;
         $display("[TB] FAIL single_result: got %h want %h", {bus1.out_cout, bus1.out_sum}, exp);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vectors        = 0;
      miscompares    = 0;
      clk            = 1'b0;
      reset          = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_a       = '0;
      bus.in_b       = '0;
      bus.in_cin     = 1'b0;
      bus.out_ready  = 1'b0;
      bus1.in_valid  = 1'b0;
      bus1.in_a      = '0;
      bus1.in_b      = '0;
      bus1.in_cin    = 1'b0;
      bus1.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_ripple();
      test_mixed();
      test_back_to_back();
      test_reset_mid();
      test_single_byte();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
